mem_block_responder: RTL

MEM_BLOCK_RESPONDER -- requirements
Module: mem_block_responder

---
 rtl/mem_block_responder.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/mem_block_responder.sv
// Block-to-beat bridge: serves one cache block request as a burst of backend beats,
// gathering read beats into a block buffer and returning a one-cycle completion pulse.
module mem_block_responder #(
    parameter int ADDR_WIDTH = 28,
    parameter int BLOCK_SIZE = 256,
    parameter int BEAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [BLOCK_SIZE-1:0] mem_wr,
    input  logic                  mem_rw,
    input  logic                  mem_valid,
    output logic [BLOCK_SIZE-1:0] mem_rd,
    output logic                  mem_ready,
    output logic [ADDR_WIDTH-1:0] ddr_addr,
    output logic [BEAT_WIDTH-1:0] ddr_wdata,
    output logic                  ddr_we,
    output logic                  ddr_req,
    input  logic [BEAT_WIDTH-1:0] ddr_rdata,
    input  logic                  ddr_ack,
    output logic                  busy
);

    localparam int BEATS = BLOCK_SIZE / BEAT_WIDTH;
    localparam int CNT_W = $clog2(BEATS);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XFER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                       state_r;
    state_t                       state_next_s;
    logic [ADDR_WIDTH-CNT_W-1:0]  addr_r;
    logic                         rw_r;
    logic [BLOCK_SIZE-1:0]        wr_r;
    logic [CNT_W-1:0]             beat_r;
    logic                         abort_r;
    logic [BLOCK_SIZE-1:0]        buf_r;
    logic [BLOCK_SIZE-1:0]        buf_next_s;
    logic [BLOCK_SIZE-1:0]        mem_rd_r;
    logic                         beat_done_s;
    logic                         abort_now_s;
    logic                         unused_addr_s;

    // Block-offset address bits are implied by the beat counter.
    assign unused_addr_s = ^mem_addr[CNT_W-1:0];

    // A request drop seen on the completing edge aborts just like an earlier drop.
    assign beat_done_s = (state_r == XFER) & ddr_ack;
    assign abort_now_s = abort_r | ~mem_valid;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (mem_valid) begin
                    state_next_s = XFER;
                end else begin
                    state_next_s = IDLE;
                end
            end
            XFER: begin
                if (beat_done_s) begin
                    if (abort_now_s) begin
                        state_next_s = IDLE;
                    end else if (beat_r == LAST_BEAT) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = XFER;
                    end
                end else begin
                    state_next_s = XFER;
                end
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Read buffer with the current beat merged in, so the last beat reaches mem_rd on the DONE entry edge.
    always_comb begin
        buf_next_s = buf_r;
        buf_next_s[int'(beat_r)*BEAT_WIDTH +: BEAT_WIDTH] = ddr_rdata;
    end

    // Request capture, beat counting, abort tracking and read data assembly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_r   <= '0;
            rw_r     <= 1'b0;
            wr_r     <= '0;
            beat_r   <= '0;
            abort_r  <= 1'b0;
            buf_r    <= '0;
            mem_rd_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (mem_valid) begin
                        addr_r  <= mem_addr[ADDR_WIDTH-1:CNT_W];
                        rw_r    <= mem_rw;
                        wr_r    <= mem_wr;
                        beat_r  <= '0;
                        abort_r <= 1'b0;
                    end
                end
                XFER: begin
                    if (!mem_valid) begin
                        abort_r <= 1'b1;
                    end
                    if (beat_done_s) begin
                        beat_r <= beat_r + CNT_W'(1);
                        if (!rw_r) begin
                            buf_r <= buf_next_s;
                            if (!abort_now_s && (beat_r == LAST_BEAT)) begin
                                mem_rd_r <= buf_next_s;
                            end
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs decoded from registered state only; nothing depends combinationally on mem_valid.
    always_comb begin
        mem_rd    = mem_rd_r;
        mem_ready = 1'b0;
        ddr_req   = 1'b0;
        ddr_we    = 1'b0;
        ddr_addr  = '0;
        ddr_wdata = '0;
        busy      = 1'b0;
        case (state_r)
            XFER: begin
                busy     = 1'b1;
                ddr_req  = 1'b1;
                ddr_we   = rw_r;
                ddr_addr = {addr_r, beat_r};
                if (rw_r) begin
                    ddr_wdata = wr_r[int'(beat_r)*BEAT_WIDTH +: BEAT_WIDTH];
                end else begin
                    ddr_wdata = '0;
                end
            end
            DONE: begin
                busy      = 1'b1;
                mem_ready = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
